down_clocking: RTL and testbench
================================

# down_clocking

Programmable clock divider for the PWM/timer block: derives a slower, 50 %-duty clock from a source clock (the Wishbone clock or an external clock, selected upstream). Contains an even-ratio divider and an odd-ratio divider. Both run from the same 16-bit divisor, and the divisor LSB selects which one drives the main output. A divisor of 0 or 1 passes the source clock through unchanged.

## Interface
- Parameters: none; widths fixed at 16 bits.
- `i_clk` in 1: source clock; the single clock; both edges are used.
- `i_rst` in 1: reset; synchronous and active-high.
- `i_divisor` in 16: division ratio D; `N = D >> 1` is the half-ratio used by both dividers.
- `o_clk_even` in/out: out 1: even-divider output, period `2N` input cycles.
- `o_clk_odd` out 1: odd-divider output, period `2N+1` input cycles.
- `o_clk` out 1: selected clock.
  - D == 0: `i_clk`.
  - D[0] == 1: `o_clk_odd`.
  - Otherwise: `o_clk_even`.

## Operation
- Even divider, N ≥ 1:
  - 16-bit counter `ce` and toggle flop `q`, both updated on posedge `i_clk`.
  - If `ce >= N-1`: `ce <= 0` and `q <= ~q`. Otherwise `ce <= ce+1`.
  - `o_clk_even = q`: N cycles high, N cycles low.
- Even divider, N == 0: `o_clk_even = i_clk` (combinational bypass).
- Odd divider, N ≥ 1:
  - 16-bit counter `co`, updated on posedge: if `co >= 2N`, `co <= 0`; otherwise `co <= co+1`.
  - Flop `a` on posedge: `a <= 1` when the next `co` value is in 1..N, else 0.
  - Flop `b` on negedge: `b <= a`.
  - `o_clk_odd = a | b`: high N+0.5 cycles, low N+0.5 cycles, exact 50 % duty.
- Odd divider, N == 0 (D == 1): `o_clk_odd = i_clk`.
- Both dividers run continuously, whichever one is selected. `o_clk` is a pure combinational mux.
- Divisor change mid-run:
  - The terminal tests use `>=`, so a counter already above the new limit wraps on the next posedge.
  - The new ratio is exact from the following period onward.
  - No lock-up is allowed for any D.
- Arithmetic: all counters 16-bit unsigned. The maximum terminal value is 2·32767 = 65534, so no overflow.

## Timing
- Reset, sampled on posedge:
  - `ce`, `co`, `q`, `a` clear to 0.
  - `b` clears on the next negedge while `i_rst` is high.
  - All three outputs are 0 while reset is held, including bypass mode: the bypass path is gated by `~i_rst`.
- After reset deasserts, counting starts at the first posedge where `i_rst` is low.
  - Even: first rising edge of `o_clk_even` at the N-th such posedge.
  - Odd: `a` rises at the first such posedge; `o_clk_odd` rises there.
- Reset asserted mid-operation: outputs go to 0 at the next posedge (`b` at the following negedge). The sequence restarts from the post-reset state.
- Latency from an `i_divisor` change: affects counter comparison at the next posedge. No additional pipelining.
- `o_clk` mux switching mid-period may produce one short pulse. This is allowed; the consumer resets after reconfiguration.

## Test plan
- D=0, reset released → `o_clk` identical to `i_clk`. D=1 → same.
- D=4 (N=2) → `o_clk` = `o_clk_even`.
  - Period 4 cycles, 2 high / 2 low.
  - First rise at the 2nd posedge after reset release.
- D=5 (N=2) → `o_clk` = `o_clk_odd`.
  - Period 5 cycles.
  - High from a posedge to the negedge 2.5 cycles later; low 2.5 cycles.
- D=65535 (N=32767) → odd period 65535 cycles, 50 % duty. D=65534 → even period 65534 cycles.
- D=20, wait until `ce`=7, then set D=4 → wrap and toggle at the next posedge. Steady period 4 thereafter.
- Reset asserted mid-period with D=6 → all outputs 0 within one edge. Release → first `o_clk` rise 3 posedges later.

Source files
------------

// File: rtl/down_clocking.sv
// Programmable clock divider: even-ratio and odd-ratio dividers sharing one
// 16-bit divisor, with the divisor LSB selecting which one drives o_clk.
module down_clocking (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_divisor,
  output logic        o_clk_even,
  output logic        o_clk_odd,
  output logic        o_clk
);

  logic [15:0] half_s;
  logic [15:0] even_lim_s;
  logic [15:0] odd_lim_s;
  logic [15:0] ce_r;
  logic [15:0] co_r;
  logic [15:0] co_nxt_s;
  logic        q_r;
  logic        a_r;
  logic        b_r;
  logic        bypass_s;

  assign half_s     = {1'b0, i_divisor[15:1]};
  assign even_lim_s = half_s - 16'd1;
  assign odd_lim_s  = {i_divisor[15:1], 1'b0};
  // Bypass path is forced low while reset is held.
  assign bypass_s   = i_clk & ~i_rst;

  // Odd-divider counter successor; >= lets a shrunken divisor wrap at once.
  always_comb begin
    co_nxt_s = 16'd0;
    if (co_r >= odd_lim_s) begin
      co_nxt_s = 16'd0;
    end else begin
      co_nxt_s = co_r + 16'd1;
    end
  end

  // Even divider: toggle q every N posedges; held cleared while N is 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ce_r <= 16'd0;
      q_r  <= 1'b0;
    end else if (half_s == 16'd0) begin
      ce_r <= 16'd0;
      q_r  <= 1'b0;
    end else if (ce_r >= even_lim_s) begin
      ce_r <= 16'd0;
      q_r  <= ~q_r;
    end else begin
      ce_r <= ce_r + 16'd1;
    end
  end

  // Odd divider rising-edge phase: a is high for counter values 1..N.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      co_r <= 16'd0;
      a_r  <= 1'b0;
    end else begin
      co_r <= co_nxt_s;
      a_r  <= (co_nxt_s != 16'd0) && (co_nxt_s <= half_s);
    end
  end

  // Half-cycle delayed copy of a, stretching a|b by half an input cycle.
  always_ff @(negedge i_clk) begin
    if (i_rst) begin
      b_r <= 1'b0;
    end else begin
      b_r <= a_r;
    end
  end

  // Output selection: bypass for ratio 0/1, otherwise the divider outputs.
  always_comb begin
    o_clk_even = q_r;
    o_clk_odd  = a_r | b_r;
    o_clk      = 1'b0;
    if (half_s == 16'd0) begin
      o_clk_even = bypass_s;
      o_clk_odd  = bypass_s;
    end else begin
      o_clk_even = q_r;
      o_clk_odd  = a_r | b_r;
    end
    if (i_divisor == 16'd0) begin
      o_clk = bypass_s;
    end else if (i_divisor[0]) begin
      o_clk = o_clk_odd;
    end else begin
      o_clk = o_clk_even;
    end
  end

endmodule

// File: tb/tb_down_clocking.sv
// Scoreboard bench for down_clocking: a phase-arithmetic model predicts every
// half-cycle of all three outputs; a monitor compares on both clock phases.
module tb_down_clocking;

  logic        clk;
  logic        i_rst;
  logic [15:0] i_divisor;
  logic        o_clk_even;
  logic        o_clk_odd;
  logic        o_clk;

  typedef struct {
    bit hi;
    bit c;
    bit e;
    bit o;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // model state: position of each divider within its current run segment
  int em     = 0;
  int om     = 0;
  int prev_n = 0;
  bit eq0    = 1'b0;
  bit a_prev = 1'b0;

  down_clocking dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_divisor  (i_divisor),
    .o_clk_even (o_clk_even),
    .o_clk_odd  (o_clk_odd),
    .o_clk      (o_clk)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input bit act, input bit exp_v, input bit hi);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s (%s phase) at %0t: got %b expected %b", name, hi ? "high" : "low", $time, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs and push the predicted high/low phase values.
  task automatic step(input bit rst, input logic [15:0] d);
    int n;
    int ce_old;
    int co_old;
    int pos;
    bit qc;
    bit eq;
    bit an;
    bit gate;
    exp_t hi_e;
    exp_t lo_e;
    @(negedge clk);
    #2;
    i_rst     = rst;
    i_divisor = d;
    n    = int'(d >> 1);
    gate = !rst;
    eq   = 1'b0;
    an   = 1'b0;
    if (rst) begin
      em = 0; om = 0; eq0 = 1'b0; prev_n = 0;
    end else begin
      if (n == 0) begin
        em = 0; om = 0; eq0 = 1'b0;
      end else if (n != prev_n) begin
        ce_old = 0; qc = 1'b0; co_old = 0;
        if (prev_n != 0) begin
          ce_old = em % prev_n;
          qc     = eq0 ^ (((em / prev_n) % 2) == 1);
          co_old = om % (2 * prev_n + 1);
        end
        if (ce_old >= n - 1) begin
          em = 0; eq0 = !qc;
        end else begin
          em = ce_old + 1; eq0 = qc;
        end
        om = (co_old >= 2 * n) ? 0 : co_old + 1;
      end else begin
        em++;
        om++;
      end
      prev_n = n;
      if (n != 0) begin
        eq  = eq0 ^ (((em / n) % 2) == 1);
        pos = om % (2 * n + 1);
        an  = (pos >= 1) && (pos <= n);
      end
    end
    hi_e.hi = 1'b1;
    lo_e.hi = 1'b0;
    hi_e.e  = (n == 0) ? gate : eq;
    lo_e.e  = (n == 0) ? 1'b0 : eq;
    hi_e.o  = (n == 0) ? gate : (an | a_prev);
    lo_e.o  = (n == 0) ? 1'b0 : an;
    if (d == 16'd0) begin
      hi_e.c = gate; lo_e.c = 1'b0;
    end else if (d[0]) begin
      hi_e.c = hi_e.o; lo_e.c = lo_e.o;
    end else begin
      hi_e.c = hi_e.e; lo_e.c = lo_e.e;
    end
    a_prev = an;
    sb.push_back(hi_e);
    sb.push_back(lo_e);
  endtask

  task automatic run(input bit rst, input logic [15:0] d, input int cycles);
    for (int i = 0; i < cycles; i++) step(rst, d);
  endtask

  // Monitor: sample just after each clock edge and compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("o_clk", o_clk, e.c, e.hi);
        chk("o_clk_even", o_clk_even, e.e, e.hi);
        chk("o_clk_odd", o_clk_odd, e.o, e.hi);
      end
    end
  end

  initial begin
    logic [15:0] d;
    int mode;
    i_rst     = 1'b1;
    i_divisor = 16'd0;
    run(1'b1, 16'd0, 3);
    run(1'b0, 16'd0, 8);
    run(1'b1, 16'd1, 2);
    run(1'b0, 16'd1, 8);
    run(1'b1, 16'd4, 2);
    run(1'b0, 16'd4, 12);
    run(1'b1, 16'd5, 2);
    run(1'b0, 16'd5, 15);
    run(1'b1, 16'd20, 2);
    run(1'b0, 16'd20, 7);
    run(1'b0, 16'd4, 12);
    run(1'b1, 16'd6, 2);
    run(1'b0, 16'd6, 4);
    run(1'b1, 16'd6, 2);
    run(1'b0, 16'd6, 10);
    for (int p = 0; p < 30; p++) begin
      mode = int'($urandom_range(0, 9));
      if (mode == 0) d = 16'd0;
      else if (mode == 1) d = 16'd1;
      else d = 16'($urandom_range(2, 40));
      if ($urandom_range(0, 3) == 0) run(1'b1, d, int'($urandom_range(1, 3)));
      run(1'b0, d, int'($urandom_range(10, 120)));
    end
    run(1'b1, 16'd65535, 2);
    run(1'b0, 16'd65535, 32800);
    run(1'b1, 16'd65534, 2);
    run(1'b0, 16'd65534, 32800);
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
